regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (en/rd/data) between NUM_REQ writeback sources, e.g. ALU writeback, load unit and debug port.
- Selects one requester per cycle by round-robin and registers the winner.
- Drives the register file's write-enable, destination and data from that register, one cycle after the grant.
- Filters writes to x0 so the register file never sees en=1 with rd=0.

Parameters:
- NUM_REQ, 2, number of write requesters (legal range 2..8).
- XLEN, 32, data width.
- PTR_W, $clog2(NUM_REQ), round-robin pointer width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the output stage and pointer.
- req_valid  in  NUM_REQ  per-requester write request.
- req_rd  in  5*NUM_REQ  destination register; requester i in bits [5i+4:5i].
- req_data  in  XLEN*NUM_REQ  write data; requester i in bits [XLEN*i+XLEN-1:XLEN*i].
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when valid and ready are both high in the same cycle.
- rf_en  out  1  register-file write enable.
- rf_rd  out  5  register-file destination.
- rf_data  out  XLEN  register-file write data.
- pend_valid  out  1  write pending in the output stage (same as rf_en); used for hazard checks.
- pend_rd  out  5  rd of the pending write.

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_en=0, rf_rd=0, rf_data=0, pend_valid=0, pend_rd=0.
  - Pointer=0; stat counters=0.
- Grant logic (combinational from req_valid and pointer):
  - Search order is pointer, pointer+1, ..., wrapping modulo NUM_REQ.
  - The first requester with req_valid=1 gets req_ready=1; all others get 0.
  - req_ready=0 everywhere when no requester is valid, when flush=1, and while rst=0.
  - req_ready never depends on req_rd or req_data.
- Output stage: the register file accepts every cycle, so the stage never back-pressures. On each clk edge:
  - flush=1: rf_en=0 and pointer=0; the output stage is cleared.
  - Else if a grant to requester g: rf_en=(req_rd[g]!=0), rf_rd=req_rd[g], rf_data=req_data[g], pointer=(g+1) mod NUM_REQ.
  - Else: rf_en=0; rf_rd and rf_data hold their last values; pointer holds.
- Latency: exactly 1 cycle from the handshake to rf_en on the port. Throughput: 1 write per cycle.
- x0 writes: the handshake completes (req_ready=1) and the pointer advances, but rf_en stays 0.
- Fairness: with all NUM_REQ valid continuously, grants rotate 0,1,...,NUM_REQ-1,0... No requester waits more than NUM_REQ-1 cycles once valid.
- Non-power-of-2 NUM_REQ: pointer wraps from NUM_REQ-1 to 0; it never holds an out-of-range value.
- Requester obligation: a requester not granted must hold valid/rd/data stable until granted. The arbiter does not check this.
- Two requesters targeting the same rd in consecutive cycles: both are written in grant order; the last grant wins.
- Reset mid-transfer: a pending rf_en is dropped immediately (asynchronous). A requester granted in that cycle treats the transfer as lost.
- flush and valid in the same cycle: no grant is given, and nothing is written the next cycle.

Optional Feature:
- Macro RFARB_STATS_EN.
- Defined:
  - Adds output stat_grants, 16*NUM_REQ bits: per-requester saturating 16-bit grant counters, lane i in bits [16i+15:16i].
  - A counter increments on each handshake of its requester, including x0 writes. It saturates at 0xFFFF.
  - Counters are cleared by rst only, not by flush.
- Not defined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then single request: release rst, req_valid=2'b01, rd=5, data=0xDEADBEEF for 1 cycle -> req_ready=2'b01 that cycle; next cycle rf_en=1, rf_rd=5, rf_data=0xDEADBEEF; following cycle rf_en=0.
- Round-robin: NUM_REQ=3, all valid for 6 cycles -> grants 0,1,2,0,1,2; rf_rd follows with 1-cycle lag; pointer back to 0.
- x0 filter: req0 rd=0, data=0x1234 -> req_ready[0]=1 and pointer advances to 1; rf_en stays 0.
- Flush: all valid with flush=1 -> req_ready=0; next cycle rf_en=0 and pointer=0; after flush drops, requester 0 is granted first.
- Async reset mid-operation: assert rst low between edges while rf_en=1 -> rf_en, rf_rd and rf_data go to 0 immediately, without waiting for a clock edge.
- RFARB_STATS_EN: 70000 back-to-back grants to req1 -> stat_grants lane 1 = 0xFFFF; lane 0 = 0; flush leaves both unchanged.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback sources.
// Define RFARB_STATS_EN to add per-requester saturating grant counters (stat_grants).
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [5*NUM_REQ-1:0]    req_rd,
  input  logic [XLEN*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rf_en,
  output logic [4:0]              rf_rd,
  output logic [XLEN-1:0]         rf_data,
`ifdef RFARB_STATS_EN
  output logic [16*NUM_REQ-1:0]   stat_grants,
`endif
  output logic                    pend_valid,
  output logic [4:0]              pend_rd
);

  logic [4:0]      rd_arr   [NUM_REQ];
  logic [XLEN-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign rd_arr[gi]   = req_rd[5*gi +: 5];
    assign data_arr[gi] = req_data[XLEN*gi +: XLEN];
  end

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             en_q, en_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;

  logic [NUM_REQ-1:0] grant_vec;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;

  // Rotating priority search starting at the pointer; the index wraps without a modulo.
  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any      = 1'b1;
        grant_idx      = PTR_W'(idx);
        grant_vec[idx] = 1'b1;
      end
    end
    if (!rst || flush) begin
      grant_vec = '0;
      grant_any = 1'b0;
    end
  end

  assign req_ready = grant_vec;

  always_comb begin
    ptr_d  = ptr_q;
    en_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (flush) begin
      ptr_d  = '0;
      rd_d   = '0;
      data_d = '0;
    end else if (grant_any) begin
      en_d   = (rd_arr[grant_idx] != 5'd0);
      rd_d   = rd_arr[grant_idx];
      data_d = data_arr[grant_idx];
      if (int'(grant_idx) == NUM_REQ - 1) ptr_d = '0;
      else                                ptr_d = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= '0;
      en_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      en_q   <= en_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign rf_en      = en_q;
  assign rf_rd      = rd_q;
  assign rf_data    = data_q;
  assign pend_valid = en_q;
  assign pend_rd    = rd_q;

`ifdef RFARB_STATS_EN
  // Counters count handshakes (x0 included) and survive flush.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [15:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = cnt_q;
      if (grant_vec[gi] && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end
    assign stat_grants[16*gi +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter (NUM_REQ=3); stat checks run when RFARB_STATS_EN is defined.
module tb_regfile_wr_arbiter;
  localparam int N  = 3;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [5*N-1:0]  req_rd;
  logic [XL*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_en;
  logic [4:0]      rf_rd;
  logic [XL-1:0]   rf_data;
  logic            pend_valid;
  logic [4:0]      pend_rd;
`ifdef RFARB_STATS_EN
  logic [16*N-1:0] stat_grants;
`endif

  regfile_wr_arbiter #(.NUM_REQ(N), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data),
`ifdef RFARB_STATS_EN
    .stat_grants(stat_grants),
`endif
    .pend_valid(pend_valid), .pend_rd(pend_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          en;
    logic [4:0]    rd;
    logic [XL-1:0] data;
  } exp_t;

  logic [N-1:0] rdy_q[$];
  exp_t         out_q[$];
  int           errors = 0;
  int           checks = 0;
  bit           mon_en = 0;

  // Reference state: pointer, visible write register and per-lane handshake counts.
  int            m_ptr = 0;
  exp_t          m_out;
  int            m_cnt [N];
  int            last_grant = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input logic [N-1:0] v, input logic [5*N-1:0] rd,
                             input logic [XL*N-1:0] d, input logic f);
    int g;
    @(negedge clk);
    req_valid = v; req_rd = rd; req_data = d; flush = f;
    g = -1;
    if (!f) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    rdy_q.push_back((g >= 0) ? N'(1 << g) : '0);
    if (f) begin
      m_out = '0;
      m_ptr = 0;
    end else if (g >= 0) begin
      m_out.rd   = rd[5*g +: 5];
      m_out.data = d[XL*g +: XL];
      m_out.en   = (m_out.rd != 0);
      m_ptr      = (g + 1) % N;
      m_cnt[g]++;
    end else begin
      m_out.en = 1'b0;
    end
    out_q.push_back(m_out);
    last_grant = g;
    $display("cycle t=%0t valid=%b flush=%b grant=%0d", $time, v, f, g);
  endtask

  // Monitor: grant checked in the issue cycle, write port one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (rdy_q.size() > 0) check("req_ready", 64'(req_ready), 64'(rdy_q.pop_front()));
        if (out_q.size() > 1) begin
          exp_t e;
          e = out_q.pop_front();
          check("rf_en", 64'(rf_en), 64'(e.en));
          check("rf_rd", 64'(rf_rd), 64'(e.rd));
          check("rf_data", 64'(rf_data), 64'(e.data));
          check("pend_valid", 64'(pend_valid), 64'(e.en));
          check("pend_rd", 64'(pend_rd), 64'(e.rd));
        end
      end
    end
  end

  logic [N-1:0]    cur_v;
  logic [5*N-1:0]  cur_rd;
  logic [XL*N-1:0] cur_d;

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_out = '0;
    rst = 1'b0; flush = 1'b0;
    req_valid = '1; req_rd = '1; req_data = '1;
    #23;
    check("reset_rf_en", 64'(rf_en), 0);
    check("reset_rf_rd", 64'(rf_rd), 0);
    check("reset_rf_data", 64'(rf_data), 0);
    check("reset_pend", 64'({pend_valid, pend_rd}), 0);
    check("reset_ready", 64'(req_ready), 0);
    @(negedge clk);
    req_valid = '0;
    #3;
    rst = 1'b1;
    out_q.push_back(m_out);
    mon_en = 1;

    // Single request, then idle.
    drive_cycle(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0);
    drive_cycle(3'b000, '0, '0, 1'b0);
    drive_cycle(3'b000, '0, '0, 1'b0);
    // Flush with all valid, then round-robin from requester 0.
    drive_cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b1);
    for (int c = 0; c < 6; c++)
      drive_cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC + 32'(c), 32'hB + 32'(c), 32'hA + 32'(c)}, 1'b0);
    // x0 write: handshake and pointer advance, no write enable.
    drive_cycle(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 1'b0);
    drive_cycle(3'b111, {5'd9, 5'd8, 5'd7}, {32'h3, 32'h2, 32'h1}, 1'b0);
    drive_cycle(3'b000, '0, '0, 1'b0);

    // Random traffic; ungranted requesters hold their request stable.
    cur_v = '0; cur_rd = '0; cur_d = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(cur_v[i] && i != last_grant)) begin
          cur_v[i] = 1'($urandom_range(0, 1));
          cur_rd[5*i +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          cur_d[XL*i +: XL] = $urandom;
        end
      end
      drive_cycle(cur_v, cur_rd, cur_d, 1'($urandom_range(0, 9) == 0));
    end
    drive_cycle(3'b000, '0, '0, 1'b0);
    drive_cycle(3'b000, '0, '0, 1'b0);
    @(negedge clk);
    #3;
    mon_en = 0;
    rdy_q.delete();
    out_q.delete();

`ifdef RFARB_STATS_EN
    for (int i = 0; i < N; i++)
      check("stat_lane", 64'(stat_grants[16*i +: 16]), 64'((m_cnt[i] > 65535) ? 65535 : m_cnt[i]));
    @(negedge clk);
    req_valid = 3'b010; flush = 1'b0;
    repeat (70000) @(negedge clk);
    req_valid = '0;
    #2;
    check("stat_lane1_sat", 64'(stat_grants[31:16]), 64'hFFFF);
    check("stat_lane0", 64'(stat_grants[15:0]), 64'((m_cnt[0] > 65535) ? 65535 : m_cnt[0]));
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #2;
    check("stat_lane1_flush", 64'(stat_grants[31:16]), 64'hFFFF);
    check("stat_lane0_flush", 64'(stat_grants[15:0]), 64'((m_cnt[0] > 65535) ? 65535 : m_cnt[0]));
`endif

    // Asynchronous reset while a write is pending on the port.
    @(negedge clk);
    req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd9}; req_data = {32'h0, 32'h0, 32'hAAAA5555};
    @(posedge clk);
    #1;
    req_valid = '0;
    #1;
    check("pre_reset_rf_en", 64'(rf_en), 1);
    check("pre_reset_rf_data", 64'(rf_data), 64'hAAAA5555);
    req_valid = 3'b111;
    rst = 1'b0;
    #1;
    check("async_rf_en", 64'(rf_en), 0);
    check("async_rf_rd", 64'(rf_rd), 0);
    check("async_rf_data", 64'(rf_data), 0);
    check("async_pend_valid", 64'(pend_valid), 0);
    check("async_ready", 64'(req_ready), 0);
`ifdef RFARB_STATS_EN
    check("async_stats", 64'(stat_grants), 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_reset_first_grant", 64'(req_ready), 64'b001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
